// File: rtl/io_buffered_port.sv
// Buffered I/O port endpoint: CPU writes stream to the device through a TX FIFO,
// device data is returned to the CPU through an RX FIFO with registered read data.
module io_buffered_port #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] WrData,
   input  logic                  WrEn,
   input  logic                  RdEn,
   output logic [DATA_WIDTH-1:0] RdData,
   output logic [DATA_WIDTH-1:0] TxData,
   output logic                  TxValid,
   input  logic                  TxReady,
   input  logic [DATA_WIDTH-1:0] RxData,
   input  logic                  RxValid,
   output logic                  RxReady,
   output logic                  TxFull,
   output logic                  RxEmpty,
   output logic                  TxOverflow,
   output logic                  RxUnderflow,
   input  logic                  ErrClr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
   logic [AW-1:0]         tx_wr_q, tx_rd_q;
   logic [AW:0]           tx_cnt_q, tx_cnt_d;
   logic                  tx_push, tx_pop;

   logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
   logic [AW-1:0]         rx_wr_q, rx_rd_q;
   logic [AW:0]           rx_cnt_q, rx_cnt_d;
   logic                  rx_push, rx_pop;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

   assign TxFull      = (tx_cnt_q == FULL_CNT);
   assign TxValid     = (tx_cnt_q != '0) && !Reset;
   assign TxData      = tx_mem_q[tx_rd_q];
   assign RxEmpty     = (rx_cnt_q == '0);
   assign RxReady     = (rx_cnt_q != FULL_CNT) && !Reset;
   assign RdData      = rd_data_q;
   assign TxOverflow  = tx_ovf_q;
   assign RxUnderflow = rx_unf_q;

   // A full TX FIFO still accepts a write when the head leaves in the same cycle.
   assign tx_pop  = TxValid && TxReady;
   assign tx_push = WrEn && !Reset && (!TxFull || tx_pop);
   assign rx_push = RxValid && RxReady;
   assign rx_pop  = RdEn && !RxEmpty && !Reset;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - 1'b1;
      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - 1'b1;
   end

   // Set beats clear when a new error coincides with ErrClr.
   always_comb begin
      tx_ovf_d = (tx_ovf_q && !ErrClr) || (WrEn && TxFull && !tx_pop);
      rx_unf_d = (rx_unf_q && !ErrClr) || (RdEn && RxEmpty);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         rd_data_q <= '0;
         tx_ovf_q  <= 1'b0;
         rx_unf_q  <= 1'b0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
         if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
         if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
         if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         if (RdEn) rd_data_q <= rx_pop ? rx_mem_q[rx_rd_q] : '0;
         tx_ovf_q <= tx_ovf_d;
         rx_unf_q <= rx_unf_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (tx_push) tx_mem_q[tx_wr_q] <= WrData;
      if (rx_push) rx_mem_q[rx_wr_q] <= RxData;
   end

endmodule

// File: tb/tb_io_buffered_port.sv
// Directed bench for io_buffered_port: TX streaming, RX reads, full/empty edges,
// sticky error flags and mid-stream reset.
module tb_io_buffered_port;
   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] WrData, RdData, TxData, RxData;
   logic        WrEn, RdEn, TxValid, TxReady, RxValid, RxReady;
   logic        TxFull, RxEmpty, TxOverflow, RxUnderflow, ErrClr;

   int checks = 0;
   int errors = 0;

   io_buffered_port #(.DATA_WIDTH(32), .DEPTH(8)) dut (
      .Clock(Clock), .Reset(Reset), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
      .RdData(RdData), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
      .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady), .TxFull(TxFull),
      .RxEmpty(RxEmpty), .TxOverflow(TxOverflow), .RxUnderflow(RxUnderflow),
      .ErrClr(ErrClr)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      logic [31:0] exp;
      Reset = 1'b1; WrData = '0; WrEn = 0; RdEn = 0; TxReady = 0;
      RxData = '0; RxValid = 0; ErrClr = 0;
      tick(); tick();
      chk("rst_txvalid", TxValid, 0);
      chk("rst_rxready", RxReady, 0);
      Reset = 1'b0;
      tick();
      chk("post_txvalid", TxValid, 0);
      chk("post_txfull", TxFull, 0);
      chk("post_rxempty", RxEmpty, 1);
      chk("post_rxready", RxReady, 1);
      chk("post_rddata", RdData, 0);
      chk("post_flags", {TxOverflow, RxUnderflow}, 0);

      // basic TX stream
      WrEn = 1; WrData = 32'h11; tick();
      chk("t1_valid", TxValid, 1);
      chk("t1_head", TxData, 32'h11);
      WrData = 32'h22; tick();
      WrData = 32'h33; tick();
      WrEn = 0; TxReady = 1;
      chk("t1_d0", TxData, 32'h11); tick();
      chk("t1_d1", TxData, 32'h22); tick();
      chk("t1_d2", TxData, 32'h33); tick();
      TxReady = 0;
      chk("t1_empty", TxValid, 0);

      // TX overflow
      for (int i = 0; i < 9; i++) begin
         WrEn = 1; WrData = 32'h100 + i; tick();
         if (i == 7) begin
            chk("t2_full8", TxFull, 1);
            chk("t2_noovf8", TxOverflow, 0);
         end
      end
      WrEn = 0;
      chk("t2_ovf", TxOverflow, 1);
      TxReady = 1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_drain", TxData, 32'h100 + i);
         tick();
      end
      TxReady = 0;
      chk("t2_empty", TxValid, 0);
      ErrClr = 1; tick(); ErrClr = 0;
      chk("t2_clr", TxOverflow, 0);

      // full TX with simultaneous pop and push
      for (int i = 0; i < 8; i++) begin
         WrEn = 1; WrData = 32'h200 + i; tick();
      end
      TxReady = 1; WrData = 32'hAA; tick();
      WrEn = 0; TxReady = 0;
      chk("t3_full", TxFull, 1);
      chk("t3_noovf", TxOverflow, 0);
      TxReady = 1;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 32'h201 + i : 32'hAA;
         chk("t3_drain", TxData, exp);
         tick();
      end
      TxReady = 0;
      chk("t3_empty", TxValid, 0);

      // RX reads and underflow
      RxValid = 1; RxData = 32'hA5; tick();
      RxData = 32'h5A; tick();
      RxValid = 0;
      chk("t4_notempty", RxEmpty, 0);
      RdEn = 1; tick(); RdEn = 0;
      chk("t4_rd0", RdData, 32'hA5);
      tick();
      chk("t4_hold", RdData, 32'hA5);
      RdEn = 1; tick(); RdEn = 0;
      chk("t4_rd1", RdData, 32'h5A);
      chk("t4_empty", RxEmpty, 1);
      RdEn = 1; tick(); RdEn = 0;
      chk("t4_unf_data", RdData, 0);
      chk("t4_unf", RxUnderflow, 1);
      ErrClr = 1; RdEn = 1; tick(); ErrClr = 0; RdEn = 0;
      chk("t4_setwins", RxUnderflow, 1);
      ErrClr = 1; tick(); ErrClr = 0;
      chk("t4_clr", RxUnderflow, 0);
      // push into empty while reading: no bypass
      RxValid = 1; RxData = 32'h77; RdEn = 1; tick(); RxValid = 0; RdEn = 0;
      chk("t4_nobyp_data", RdData, 0);
      chk("t4_nobyp_unf", RxUnderflow, 1);
      chk("t4_nobyp_stored", RxEmpty, 0);
      RdEn = 1; tick(); RdEn = 0;
      chk("t4_nobyp_rd", RdData, 32'h77);
      ErrClr = 1; tick(); ErrClr = 0;

      // RX full back-pressure and wrap-around
      for (int i = 0; i < 8; i++) begin
         RxValid = 1; RxData = 32'h300 + i; tick();
      end
      chk("t5_full", RxReady, 0);
      RxData = 32'h3FF; tick(); tick();
      chk("t5_held", RxReady, 0);
      RdEn = 1; tick(); RdEn = 0;
      chk("t5_rd0", RdData, 32'h300);
      chk("t5_ready", RxReady, 1);
      tick();
      RxValid = 0;
      chk("t5_refull", RxReady, 0);
      RdEn = 1; tick();
      chk("t5_rd1", RdData, 32'h301);
      for (int k = 0; k < 20; k++) begin
         RxValid = 1; RxData = 32'h400 + k; tick();
         exp = (k < 6) ? 32'h302 + k : (k == 6) ? 32'h3FF : 32'h400 + (k - 7);
         chk("t5_wrap", RdData, exp);
      end
      RxValid = 0;
      for (int k = 13; k < 20; k++) begin
         tick();
         chk("t5_tail", RdData, 32'h400 + k);
      end
      RdEn = 0;
      chk("t5_empty", RxEmpty, 1);
      chk("t5_nounf", RxUnderflow, 0);

      // mid-stream reset
      for (int i = 0; i < 3; i++) begin
         WrEn = 1; WrData = 32'h500 + i; tick();
      end
      WrEn = 0;
      RxValid = 1; RxData = 32'h600; tick();
      RxData = 32'h601; tick();
      RxValid = 0;
      RdEn = 1; tick(); RdEn = 0;
      chk("t6_pre_rd", RdData, 32'h600);
      Reset = 1; WrEn = 1; WrData = 32'hDEAD; TxReady = 1; RxValid = 1; RdEn = 1;
      tick();
      chk("t6_in_txvalid", TxValid, 0);
      chk("t6_in_rxready", RxReady, 0);
      Reset = 0; WrEn = 0; TxReady = 0; RxValid = 0; RdEn = 0;
      tick();
      chk("t6_txvalid", TxValid, 0);
      chk("t6_rxempty", RxEmpty, 1);
      chk("t6_rddata", RdData, 0);
      chk("t6_flags", {TxOverflow, RxUnderflow}, 0);
      WrEn = 1; WrData = 32'h55; tick(); WrEn = 0;
      chk("t6_new_head", TxData, 32'h55);
      TxReady = 1; tick(); TxReady = 0;
      chk("t6_no_old", TxValid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_buffered_port.md
Name: io_buffered_port

Overview:
- Slave-side responder for the I/O access interface. The CPU-side master issues WrData/WrEn/RdEn; this block is the peripheral endpoint.
- CPU writes are queued in a TX FIFO and streamed to a device over a valid/ready handshake.
- Device data is collected in an RX FIFO and returned to the CPU on RdEn through a registered RdData.
- Instantiated once per buffered peripheral, such as a UART or SPI data port.

Parameters:
DATA_WIDTH  32  width of WrData, RdData, TxData and RxData
DEPTH  8  entries per FIFO; power of two, at least 2

Ports:
Clock  in  1  single clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
WrData  in  DATA_WIDTH  write data from the access master
WrEn  in  1  write enable; one push request per cycle high
RdEn  in  1  read enable; one pop request per cycle high
RdData  out  DATA_WIDTH  registered read data
TxData  out  DATA_WIDTH  head of the TX FIFO, toward the device
TxValid  out  1  TX FIFO not empty
TxReady  in  1  device accepts TxData
RxData  in  DATA_WIDTH  data from the device
RxValid  in  1  RxData valid
RxReady  out  1  RX FIFO not full
TxFull  out  1  TX FIFO full
RxEmpty  out  1  RX FIFO empty
TxOverflow  out  1  sticky: a write was dropped because the TX FIFO was full
RxUnderflow  out  1  sticky: a read occurred while the RX FIFO was empty
ErrClr  in  1  clears both sticky error flags

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high on Reset.
- Reset clears both FIFOs (pointers and counts to 0), RdData=0, TxOverflow=0, RxUnderflow=0.
  - While Reset is high: TxValid=0, RxReady=0.
  - In the first cycle after Reset falls: TxValid=0, TxFull=0, RxEmpty=1, RxReady=1.
- Reset asserted mid-operation discards all FIFO contents with no drain; any in-flight handshake that cycle is ignored.
- Each FIFO uses read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits. Full means count==DEPTH; empty means count==0.
- TX push: occurs when WrEn=1 and (count<DEPTH, or a TX pop happens in the same cycle).
  - Push when full with a same-cycle pop is accepted; count is unchanged.
  - WrEn=1 while full with no pop: data is dropped and TxOverflow is set at the next edge.
- TX output is first-word-fall-through.
  - TxValid=(count!=0). TxData=mem[rd_ptr], combinational from registered state.
  - Pop occurs on TxValid&&TxReady.
  - A word written at edge N is visible on TxData/TxValid after edge N; minimum latency is 1 cycle.
- RX push: occurs on RxValid&&RxReady. RxReady=!RxFull is computed from registered count, so no push happens while full, even if RdEn pops that cycle.
- RX read: latency 1.
  - RdEn=1 with RxEmpty=0: pop; RdData<=mem[rd_ptr] at the same edge.
  - RdEn=1 with RxEmpty=1: RdData<=0 and RxUnderflow is set.
  - A same-cycle RX push into an empty FIFO is not bypassed; the read still underflows, and the pushed word stays stored.
  - RdData holds its value when RdEn=0.
- Simultaneous RX push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Sticky flags: ErrClr=1 clears both flags at the next edge. If a new error occurs in the same cycle as ErrClr, set wins.
- WrEn and RdEn in the same cycle are independent and both are serviced.
- TxFull and RxEmpty are combinational from the counts.

Test Plan:
- Reset, then hold TxReady=0 and write 0x11,0x22,0x33 -> TxValid=1 from the cycle after the first write, TxData=0x11. Raise TxReady for 3 cycles -> device sees 0x11,0x22,0x33 in order, then TxValid=0.
- TxReady=0, write 9 words 0x100..0x108 with DEPTH=8 -> TxFull=1 after the 8th write; the 9th is dropped and TxOverflow=1. Drain -> exactly 0x100..0x107. Pulse ErrClr -> TxOverflow=0.
- TX full with TxReady=1 and WrEn=1 with 0xAA in the same cycle -> 0xAA accepted, TxFull stays 1, TxOverflow stays 0.
- Device pushes 0xA5 and 0x5A, then RdEn one cycle at a time -> RdData=0xA5 one cycle after the first RdEn and 0x5A after the second. RxEmpty=1 afterwards. A third RdEn -> RdData=0, RxUnderflow=1.
- Fill RX with 8 words -> RxReady=0 and RxValid held high is not consumed. One RdEn -> RxReady=1 the next cycle and the held word is accepted. Later reads return it last, with wrap-around order preserved across 20 push/pop cycles.
- Load TX with 3 words and RX with 2, assert Reset for one cycle mid-stream -> TxValid=0, RxEmpty=1, RdData=0, flags=0. Old data is never emitted.
